// File: rtl/alu_operand_issue_if.sv
// Handshake bundle around alu_operand_issue: decode-side input (instr + register data) and the
// ALU-facing head-of-queue outputs. The DUT uses the slave view, the driving environment the master.
interface alu_operand_issue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REGA_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [5:0]        func;
  logic [REGA_W-1:0] dest;

  modport slave (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, func, dest
  );

  modport master (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, func, dest
  );
endinterface

// File: rtl/alu_operand_issue.sv
// Execute-stage front end: decodes a MIPS word + register data into ALU operands and buffers them
// in a 2-entry skid queue. Define ALU_ISSUE_LUI_EN to make lui (op 0F) a legal instruction.
module alu_operand_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REGA_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  alu_operand_issue_if.slave   bus,
  output logic                 illegal_insn
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [5:0]        func;
    logic [REGA_W-1:0] dest;
  } entry_t;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
`ifdef ALU_ISSUE_LUI_EN
  localparam logic [5:0] OpLui   = 6'h0F;
`endif

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic        unused_rs_idx;

  assign opcode        = bus.instr[31:26];
  assign rt_idx        = bus.instr[20:16];
  assign rd_idx        = bus.instr[15:11];
  assign shamt         = bus.instr[10:6];
  assign funct         = bus.instr[5:0];
  assign imm           = bus.instr[15:0];
  // rs arrives already read out as rs_data; the index itself is not needed here.
  assign unused_rs_idx = ^bus.instr[25:21];

  entry_t dec;
  logic   dec_legal;

  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    case (opcode)
      OpRType: begin
        dec.b    = bus.rt_data;
        dec.dest = REGA_W'(rd_idx);
        case (funct)
          FnSll, FnSrl, FnSra: begin
            dec.a     = DATA_W'(shamt);
            dec.func  = funct;
            dec_legal = 1'b1;
          end
          FnSllv, FnSrlv, FnSrav: begin
            dec.a     = DATA_W'(bus.rs_data[4:0]);
            dec.func  = funct;
            dec_legal = 1'b1;
          end
          FnAdd, FnAddu: begin
            dec.a     = bus.rs_data;
            dec.func  = FnAdd;
            dec_legal = 1'b1;
          end
          FnSub, FnSubu: begin
            dec.a     = bus.rs_data;
            dec.func  = FnSub;
            dec_legal = 1'b1;
          end
          FnAnd, FnOr, FnXor, FnNor: begin
            dec.a     = bus.rs_data;
            dec.func  = funct;
            dec_legal = 1'b1;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OpAddi, OpAddiu: begin
        dec.a     = bus.rs_data;
        dec.b     = {{(DATA_W-16){imm[15]}}, imm};
        dec.func  = FnAdd;
        dec.dest  = REGA_W'(rt_idx);
        dec_legal = 1'b1;
      end
      OpAndi, OpOri, OpXori: begin
        dec.a     = bus.rs_data;
        dec.b     = DATA_W'(imm);
        // andi/ori/xori map onto and/or/xor by the low two opcode bits
        dec.func  = {4'b1001, opcode[1:0]};
        dec.dest  = REGA_W'(rt_idx);
        dec_legal = 1'b1;
      end
`ifdef ALU_ISSUE_LUI_EN
      OpLui: begin
        // ALU performs b << a, producing imm << 16
        dec.a     = DATA_W'(16);
        dec.b     = DATA_W'(imm);
        dec.func  = FnSll;
        dec.dest  = REGA_W'(rt_idx);
        dec_legal = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // Queue state: head drives the ALU directly, skid holds the second entry.
  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic       illegal_q, illegal_d;

  logic accept;
  logic pop;
  logic push;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = accept & dec_legal;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    skid_d    = skid_q;
    illegal_d = 1'b0;
    if (flush) begin
      // Head contents stay on the outputs; only occupancy is cleared.
      count_d = 2'd0;
    end else begin
      illegal_d = accept & ~dec_legal;
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = dec;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          unique case ({push, pop})
            2'b10: begin
              skid_d  = dec;
              count_d = 2'd2;
            end
            2'b01:   count_d = 2'd0;
            2'b11:   head_d  = dec;
            default: count_d = count_q;
          endcase
        end
        2'd2: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      skid_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.operand_a = head_q.a;
  assign bus.operand_b = head_q.b;
  assign bus.func      = head_q.func;
  assign bus.dest      = head_q.dest;
  assign illegal_insn  = illegal_q;

endmodule
